ptw_walker: RTL
===============

# ptw_walker

Two-level page table walker that serves TLB misses in the MMU. It accepts a virtual address on the PTW request channel and issues one or two 32-bit reads to memory through a single-outstanding read port. It returns a leaf PTE to the TLB in compact form: `{ppn[19:0], 10'b0, W, R}`. Every fault is reported as an all-zero PTE, so the TLB sees no permissions and raises its own fault.

## Interface
- `MEM_TIMEOUT`, default 255: memory-response wait limit in cycles, range 2..255.
- `TO_BITS`, default 8: width of the timeout counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `root_ppn_i`  in  20  root table PPN; sampled at request acceptance.
- `ptw_req_valid_i`  in  1  TLB walk request.
- `ptw_req_ready_o`  out  1  walker can accept a request.
- `ptw_vaddr_i`  in  32  virtual address to translate.
- `ptw_resp_valid_o`  out  1  PTE result valid.
- `ptw_resp_ready_i`  in  1  TLB accepts the result.
- `ptw_pte_o`  out  32  compact leaf PTE, or 0 on fault.
- `mem_req_valid_o`  out  1  memory read request.
- `mem_req_ready_i`  in  1  memory accepts the request.
- `mem_addr_o`  out  32  word-aligned PTE address.
- `mem_resp_valid_i`  in  1  read data valid; always accepted, no ready.
- `mem_rdata_i`  in  32  raw PTE.
- `busy_o`  out  1  walker is not in IDLE.

## Operation
- Memory PTE format: [31:12] PPN, [2] V, [1] W, [0] R.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP.
- IDLE:
  - `ptw_req_ready_o` = 1.
  - On `ptw_req_valid_i`: latch vaddr and `root_ppn_i`, go to L1_REQ.
- L1_REQ:
  - `mem_addr_o` = `{root_ppn, vaddr[31:22], 2'b00}`.
  - On the mem handshake, go to L1_WAIT.
- L1_WAIT, on response:
  - V=0: fault.
  - V=1 and W,R = 00: pointer. Latch PPN, go to L0_REQ.
  - V=1 and W,R ≠ 00: leaf at level 1. Handling depends on the configuration macro (see Configuration).
- L0_REQ:
  - `mem_addr_o` = `{l1_ppn, vaddr[21:12], 2'b00}`.
- L0_WAIT, on response:
  - V=0, or W,R = 00: fault.
  - Otherwise: result = `{rdata[31:12], 10'b0, rdata[1:0]}`.
- RESP:
  - `ptw_resp_valid_o` = 1, with `ptw_pte_o` held stable.
  - On `ptw_resp_ready_i`: go to IDLE.
- Fault handling: result = 32'h0, go to RESP.
- Timeout:
  - The counter clears on entry to each WAIT state and increments on each WAIT cycle without a response.
  - After `MEM_TIMEOUT` WAIT cycles without a response: fault, and set `stale` = 1.
- Stale handling:
  - While `stale` = 1, the next `mem_resp_valid_i` is discarded and clears `stale`.
  - While `stale` = 1, `mem_req_valid_o` is held 0 in the REQ states.
- `mem_resp_valid_i` outside WAIT states with `stale` = 0 is a protocol error and is ignored.
- Only one memory request is outstanding at a time; `mem_req_valid_o` is held with a stable address until ready.

## Timing
- Reset values:
  - `ptw_req_ready_o` = 1.
  - `ptw_resp_valid_o` = 0.
  - `ptw_pte_o` = 0.
  - `mem_req_valid_o` = 0.
  - `mem_addr_o` = 0.
  - `busy_o` = 0.
  - `stale` = 0, counter = 0, state = IDLE.
- Reset mid-walk aborts the walk immediately and does not reply.
- Outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Request acceptance at cycle 0 → L1_REQ at cycle 1.
- With zero-wait memory (ready=1, response in the first WAIT cycle):
  - Two-level walk: `ptw_resp_valid_o` high at cycle 5.
  - Level-1 leaf or level-1 fault: high at cycle 3.
- Timeout fault: RESP is entered on the cycle after the `MEM_TIMEOUT`-th WAIT cycle.
- The next request can be accepted on the cycle after the RESP handshake.

## Configuration
- `PTW_SUPERPAGE_EN` defined: a level-1 leaf is a 4 MiB superpage.
  - If `ppn[9:0]` ≠ 0 → fault (misaligned).
  - Otherwise result = `{ppn[19:10], vaddr[21:12], 10'b0, W, R}`.
- `PTW_SUPERPAGE_EN` undefined: any level-1 leaf is a fault. No L0 read is issued.

## Test plan
- Normal two-level walk:
  - Stimulus: `root_ppn` = 0x00010, vaddr = 0x12345678.
  - Expect read 0x00010120 → return 0x00020004.
  - Expect read 0x00020D14 → return 0xABCDE007.
  - Expect `ptw_pte_o` = 0xABCDE003 at cycle 5.
- Invalid level 1: return 0x00000000 → exactly one mem read, `ptw_pte_o` = 0 at cycle 3.
- Superpage: level-1 PTE 0x45400005.
  - With `PTW_SUPERPAGE_EN`: `ptw_pte_o` = 0x45745001.
  - Without it: 0x00000000.
  - With PTE 0x45600005 and the macro defined: 0x00000000.
- Timeout and stale drain:
  - Stimulus: `MEM_TIMEOUT` = 16, no response in L1_WAIT.
  - Expect result 0 after 16 WAIT cycles.
  - A late response arriving in IDLE is dropped.
  - The next walk's first read waits for the drain, then completes correctly.
- Backpressure:
  - Stimulus: `ptw_resp_ready_i` low for 3 cycles, `mem_req_ready_i` low for 2 cycles.
  - Expect valid and data stable, `ptw_req_ready_o` = 0, and the address held.
- Reset during L0_WAIT: all outputs return to reset values the next cycle, and a fresh walk succeeds.

Source files
------------

// File: rtl/ptw_walker_if.sv
// Request, response and memory-read channels of the page table walker.
// The slave modport is the walker side; the master modport is the MMU/memory side.
interface ptw_walker_if;
    logic [19:0] root_ppn_i;
    logic        ptw_req_valid_i;
    logic        ptw_req_ready_o;
    logic [31:0] ptw_vaddr_i;
    logic        ptw_resp_valid_o;
    logic        ptw_resp_ready_i;
    logic [31:0] ptw_pte_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;

    modport slave (
        input  root_ppn_i, ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
               mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
        output ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o,
               mem_req_valid_o, mem_addr_o, busy_o
    );

    modport master (
        output root_ppn_i, ptw_req_valid_i, ptw_vaddr_i, ptw_resp_ready_i,
               mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
        input  ptw_req_ready_o, ptw_resp_valid_o, ptw_pte_o,
               mem_req_valid_o, mem_addr_o, busy_o
    );
endinterface

// File: rtl/ptw_walker.sv
// Two-level page table walker returning compact leaf PTEs {ppn, 10'b0, W, R}; faults return 0.
// Define PTW_SUPERPAGE_EN to accept aligned level-1 leaves as 4 MiB superpages.
module ptw_walker #(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_BITS     = 8
) (
    input logic         clk,
    input logic         rst,
    ptw_walker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP} state_t;

    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(MEM_TIMEOUT - 1);

    state_t             state, state_nxt;
    logic               stale, stale_nxt;
    logic [TO_BITS-1:0] cnt, cnt_nxt;
    logic [31:0]        pte, pte_nxt;
    logic [19:0]        root, root_nxt;
    logic [19:0]        l1_ppn, l1_ppn_nxt;
    logic [19:0]        vpn, vpn_nxt;
    logic [31:0]        mem_addr;
    logic               resp_hit;
    logic               pte_v;
    logic               pte_ptr;
    logic               unused_rdata;

    function automatic logic [31:0] leaf_pte(input logic [31:0] raw);
        return {raw[31:12], 10'b0, raw[1:0]};
    endfunction

`ifdef PTW_SUPERPAGE_EN
    // A superpage must be 4 MiB aligned; the low VPN fills the low PPN bits.
    function automatic logic [31:0] super_pte(input logic [31:0] raw, input logic [9:0] vpn0);
        if (raw[21:12] != 10'b0) return 32'h0;
        return {raw[31:22], vpn0, 10'b0, raw[1:0]};
    endfunction
`endif

    assign resp_hit     = bus.mem_resp_valid_i && !stale;
    assign pte_v        = bus.mem_rdata_i[2];
    assign pte_ptr      = bus.mem_rdata_i[1:0] == 2'b00;
    assign unused_rdata = ^bus.mem_rdata_i[11:3];

    always_comb begin
        state_nxt  = state;
        stale_nxt  = stale;
        cnt_nxt    = cnt;
        pte_nxt    = pte;
        root_nxt   = root;
        l1_ppn_nxt = l1_ppn;
        vpn_nxt    = vpn;
        // The first response after a timeout belongs to the abandoned read.
        if (stale && bus.mem_resp_valid_i) stale_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.ptw_req_valid_i) begin
                    root_nxt  = bus.root_ppn_i;
                    vpn_nxt   = bus.ptw_vaddr_i[31:12];
                    state_nxt = L1_REQ;
                end
            end
            L1_REQ, L0_REQ: begin
                if (!stale && bus.mem_req_ready_i) begin
                    cnt_nxt   = '0;
                    state_nxt = (state == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end
            L1_WAIT, L0_WAIT: begin
                if (resp_hit) begin
                    state_nxt = RESP;
                    pte_nxt   = 32'h0;
                    if (state == L1_WAIT && pte_v && pte_ptr) begin
                        l1_ppn_nxt = bus.mem_rdata_i[31:12];
                        state_nxt  = L0_REQ;
                    end else if (state == L1_WAIT && pte_v) begin
`ifdef PTW_SUPERPAGE_EN
                        pte_nxt = super_pte(bus.mem_rdata_i, vpn[9:0]);
`endif
                    end else if (state == L0_WAIT && pte_v && !pte_ptr) begin
                        pte_nxt = leaf_pte(bus.mem_rdata_i);
                    end
                end else if (cnt == TO_LAST) begin
                    state_nxt = RESP;
                    pte_nxt   = 32'h0;
                    stale_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + TO_BITS'(1);
                end
            end
            RESP: begin
                if (bus.ptw_resp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            stale <= 1'b0;
            cnt   <= '0;
            pte   <= 32'h0;
        end else begin
            state <= state_nxt;
            stale <= stale_nxt;
            cnt   <= cnt_nxt;
            pte   <= pte_nxt;
        end
    end

    always_ff @(posedge clk) begin
        root   <= root_nxt;
        l1_ppn <= l1_ppn_nxt;
        vpn    <= vpn_nxt;
    end

    always_comb begin
        mem_addr = 32'h0;
        case (state)
            L1_REQ:  mem_addr = {root, vpn[19:10], 2'b00};
            L0_REQ:  mem_addr = {l1_ppn, vpn[9:0], 2'b00};
            default: mem_addr = 32'h0;
        endcase
    end

    assign bus.ptw_req_ready_o  = state == IDLE;
    assign bus.busy_o           = state != IDLE;
    assign bus.ptw_resp_valid_o = state == RESP;
    assign bus.ptw_pte_o        = pte;
    assign bus.mem_req_valid_o  = (state == L1_REQ || state == L0_REQ) && !stale;
    assign bus.mem_addr_o       = mem_addr;
endmodule
